// File: rtl/scan_pkg.sv
// Shared types and default widths for the scan access port.
package scan_pkg;

  localparam int SCAN_IN_W  = 4;
  localparam int SCAN_OUT_W = 1;
  localparam int VEC_CNT_W  = 16;
  localparam int SEQ_CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    APPLY,
    CAPTURE,
    UNLOAD,
    DONE
  } scan_state_t;

endpackage

// File: rtl/scan_shift_reg.sv
// Left-shifting register with parallel load; serial data enters at the LSB and leaves at the MSB.
module scan_shift_reg #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         sin,
  output logic         sout,
  output logic [W-1:0] q_next
);

  logic [W-1:0] q;
  logic [W-1:0] shifted;

  generate
    if (W == 1) begin : g_single
      assign shifted = sin;
    end else begin : g_multi
      assign shifted = {q[W-2:0], sin};
    end
  endgenerate

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= shifted;
    end
  end

  // q_next lets the owner capture a completed word on the same edge as its final shift.
  assign q_next = shifted;
  assign sout   = q[W-1];

endmodule

// File: rtl/scan_access_port.sv
// Serial scan port: loads a vector, applies it to the core, captures the response and unloads it.
module scan_access_port
  import scan_pkg::*;
#(
  parameter int IN_W   = SCAN_IN_W,
  parameter int OUT_W  = SCAN_OUT_W,
  parameter int SETTLE = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 si,
  input  logic                 si_valid,
  output logic                 si_ready,
  output logic                 so,
  output logic                 so_valid,
  input  logic                 so_ready,
  output logic [IN_W-1:0]      core_in,
  input  logic [OUT_W-1:0]     core_out,
  output logic [VEC_CNT_W-1:0] vec_count
);

  localparam logic [SEQ_CNT_W-1:0] LOAD_LAST   = SEQ_CNT_W'(IN_W - 1);
  localparam logic [SEQ_CNT_W-1:0] SETTLE_LAST = SEQ_CNT_W'(SETTLE - 1);
  localparam logic [SEQ_CNT_W-1:0] UNLOAD_LAST = SEQ_CNT_W'(OUT_W - 1);

  scan_state_t          state;
  scan_state_t          state_next;
  logic [SEQ_CNT_W-1:0] cnt;
  logic                 scan_shift;
  logic                 resp_load;
  logic                 resp_shift;
  logic [IN_W-1:0]      scan_next;
  logic                 scan_sout_unused;
  logic [OUT_W-1:0]     resp_next_unused;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (si_valid && cnt == LOAD_LAST) state_next = APPLY;
      APPLY:   if (cnt == SETTLE_LAST) state_next = CAPTURE;
      CAPTURE: state_next = UNLOAD;
      UNLOAD:  if (so_ready && cnt == UNLOAD_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    si_ready   = (state == LOAD);
    so_valid   = (state == UNLOAD);
    done       = (state == DONE);
    resp_load  = (state == CAPTURE);
    scan_shift = si_ready && si_valid;
    resp_shift = so_valid && so_ready;
  end

  // One counter serves bits loaded, settle cycles and bits unloaded; it restarts on every state change.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else if (scan_shift || state == APPLY || resp_shift) begin
      cnt <= cnt + 1'b1;
    end
  end

  // core_in only changes when a full vector is in hand, so the core never sees a partial shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      core_in <= '0;
    end else if (state == LOAD && state_next == APPLY) begin
      core_in <= scan_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vec_count <= '0;
    end else if (done && vec_count != '1) begin
      vec_count <= vec_count + 1'b1;
    end
  end

  scan_shift_reg #(.W(IN_W)) u_scan_chain (
    .clock     (clock),
    .reset     (reset),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  (scan_shift),
    .sin       (si),
    .sout      (scan_sout_unused),
    .q_next    (scan_next)
  );

  scan_shift_reg #(.W(OUT_W)) u_resp_chain (
    .clock     (clock),
    .reset     (reset),
    .load      (resp_load),
    .load_data (core_out),
    .shift_en  (resp_shift),
    .sin       (1'b0),
    .sout      (so),
    .q_next    (resp_next_unused)
  );

endmodule

// File: tb/tb_scan_access_port.sv
// Bench for scan_access_port with an XOR-reduction core; responses are checked through a scoreboard queue.
module tb_scan_access_port;

  localparam int IN_W  = 4;
  localparam int OUT_W = 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             busy;
  logic             done;
  logic             si;
  logic             si_valid;
  logic             si_ready;
  logic             so;
  logic             so_valid;
  logic             so_ready;
  logic [IN_W-1:0]  core_in;
  logic [OUT_W-1:0] core_out;
  logic [15:0]      vec_count;

  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          done_cnt  = 0;
  int          exp_done  = 0;
  logic [15:0] exp_vc;
  logic [3:0]  cur_core;
  logic        exp_q[$];
  logic        sb_exp;

  always #5 clock = ~clock;

  assign core_out = ^core_in;

  scan_access_port dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .si        (si),
    .si_valid  (si_valid),
    .si_ready  (si_ready),
    .so        (so),
    .so_valid  (so_valid),
    .so_ready  (so_ready),
    .core_in   (core_in),
    .core_out  (core_out),
    .vec_count (vec_count)
  );

  // Count done pulses and check every accepted response bit against the scoreboard.
  always @(negedge clock) begin
    if (done === 1'b1) done_cnt++;
    if (reset === 1'b0 && so_valid === 1'b1 && so_ready === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_empty: so=%0b with no expected response", so);
      end else begin
        sb_exp = exp_q.pop_front();
        if (so !== sb_exp) $display("FAIL so_response: got %0b want %0b", so, sb_exp);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    start    = 1'b0;
    si       = 1'b0;
    si_valid = 1'b0;
    so_ready = 1'b0;
    step();
    step();
    reset    = 1'b0;
    cur_core = 4'b0000;
    exp_vc   = 16'd0;
  endtask

  // Runs one full sequence; gap = idle cycles between scan bits, stall = so_ready-low cycles in UNLOAD,
  // poke = assert start during LOAD, UNLOAD and DONE.
  task automatic run_vector(input logic [3:0] vec, input int gap, input int stall, input bit poke);
    int   cyc;
    int   n;
    int   exp_lat;
    logic exp_so;
    exp_so   = ^vec;
    exp_lat  = 1 + IN_W + 1 + 1 + OUT_W + 1 + gap * (IN_W - 1) + stall;
    so_ready = (stall == 0);
    start    = 1'b1;
    step();
    start    = 1'b0;
    cyc      = 1;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL busy_after_start: got %0b want 1", busy);
    else pass_cnt++;
    for (int i = 0; i < IN_W; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          si_valid = 1'b0;
          step();
          cyc++;
          total_cnt++;
          if (core_in !== cur_core) $display("FAIL core_in_gap: got %b want %b", core_in, cur_core);
          else pass_cnt++;
        end
      end
      total_cnt++;
      if (core_in !== cur_core || si_ready !== 1'b1)
        $display("FAIL load_hold: core_in=%b si_ready=%0b want core_in=%b si_ready=1", core_in, si_ready, cur_core);
      else pass_cnt++;
      si       = vec[IN_W-1-i];
      si_valid = 1'b1;
      start    = poke && (i == 1);
      step();
      cyc++;
      start    = 1'b0;
    end
    si_valid = 1'b0;
    si       = 1'b0;
    total_cnt++;
    if (core_in !== vec) $display("FAIL core_in_applied: got %b want %b", core_in, vec);
    else pass_cnt++;
    total_cnt++;
    if (si_ready !== 1'b0) $display("FAIL si_ready_drop: got %0b want 0", si_ready);
    else pass_cnt++;
    exp_q.push_back(exp_so);
    cur_core = vec;

    n = 0;
    while (so_valid !== 1'b1 && n < 16) begin
      step();
      cyc++;
      n++;
    end
    total_cnt++;
    if (so_valid !== 1'b1) $display("FAIL unload_timeout: so_valid=%0b want 1", so_valid);
    else pass_cnt++;
    repeat (stall) begin
      total_cnt++;
      if (so !== exp_so || so_valid !== 1'b1)
        $display("FAIL so_stall_hold: so=%0b so_valid=%0b want so=%0b so_valid=1", so, so_valid, exp_so);
      else pass_cnt++;
      step();
      cyc++;
    end
    so_ready = 1'b1;
    start    = poke;
    n = 0;
    while (done !== 1'b1 && n < 16) begin
      step();
      cyc++;
      n++;
      start = 1'b0;
    end
    start = 1'b0;
    total_cnt++;
    if (done !== 1'b1) $display("FAIL done_timeout: done=%0b want 1", done);
    else pass_cnt++;
    total_cnt++;
    if (cyc + 1 !== exp_lat) $display("FAIL latency: done in cycle %0d want %0d", cyc + 1, exp_lat);
    else pass_cnt++;
    exp_done++;
    if (exp_vc != 16'hFFFF) exp_vc = exp_vc + 16'd1;
    start = poke;
    step();
    start = 1'b0;
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL idle_after_done: done=%0b busy=%0b want 0 0", done, busy);
    else pass_cnt++;
    total_cnt++;
    if (vec_count !== exp_vc) $display("FAIL vec_count: got %0d want %0d", vec_count, exp_vc);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== exp_done) $display("FAIL done_pulses: got %0d want %0d", done_cnt, exp_done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      total_cnt++;
      if ({busy, si_ready, so_valid, done} !== 4'b0000)
        $display("FAIL reset_ctrl: busy/si_ready/so_valid/done=%b want 0000", {busy, si_ready, so_valid, done});
      else pass_cnt++;
      total_cnt++;
      if (core_in !== 4'b0000 || vec_count !== 16'd0)
        $display("FAIL reset_data: core_in=%b vec_count=%0d want 0000 0", core_in, vec_count);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_basic();
    run_vector(4'b0011, 0, 0, 1'b0);
  endtask

  task automatic test_stalls();
    run_vector(4'b0111, 3, 5, 1'b0);
  endtask

  task automatic test_no_glitch();
    run_vector(4'b1100, 0, 0, 1'b0);
    run_vector(4'b0001, 1, 0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    logic [3:0] vecs [7];
    vecs = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100};
    apply_reset();
    foreach (vecs[k]) run_vector(vecs[k], 0, 0, 1'b1);
    total_cnt++;
    if (vec_count !== 16'd7) $display("FAIL back_to_back_count: got %0d want 7", vec_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    step();
    start    = 1'b0;
    si       = 1'b1;
    si_valid = 1'b1;
    step();
    step();
    si_valid = 1'b0;
    reset    = 1'b1;
    step();
    total_cnt++;
    if ({busy, si_ready, so_valid, done} !== 4'b0000)
      $display("FAIL mid_reset_ctrl: busy/si_ready/so_valid/done=%b want 0000", {busy, si_ready, so_valid, done});
    else pass_cnt++;
    total_cnt++;
    if (core_in !== 4'b0000 || vec_count !== 16'd0)
      $display("FAIL mid_reset_data: core_in=%b vec_count=%0d want 0000 0", core_in, vec_count);
    else pass_cnt++;
    reset    = 1'b0;
    cur_core = 4'b0000;
    exp_vc   = 16'd0;
    step();
    total_cnt++;
    if (done_cnt !== exp_done) $display("FAIL mid_reset_no_done: got %0d want %0d", done_cnt, exp_done);
    else pass_cnt++;
    run_vector(4'b1110, 0, 0, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    si       = 1'b0;
    si_valid = 1'b0;
    so_ready = 1'b0;
    cur_core = 4'b0000;
    exp_vc   = 16'd0;
    test_reset();
    test_basic();
    test_stalls();
    test_no_glitch();
    test_start_while_busy();
    test_reset_mid();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d responses left, want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/scan_access_port.md
Name: scan_access_port

Overview:
- Device-side scan access port for a small combinational core under test.
- A tester streams one test vector in serially. The block then:
  - applies the vector in parallel to the core inputs;
  - waits a settle time;
  - captures the core outputs;
  - streams the response back serially.
- Sits between the tester/scan pins and the core. Lets the fault-detection vector set (4-bit patterns, 1-bit response) be run through a scan path instead of direct pins.

Parameters:
- IN_W, 4, core input width = scan-in chain length
- OUT_W, 1, core output width = scan-out chain length
- SETTLE, 1, cycles (>=1) between driving core_in and capturing core_out

Ports:
- clock  input  1  single clock, all logic rising-edge
- reset  input  1  synchronous, active-high
- start  input  1  begin one load/apply/capture/unload sequence (sampled in IDLE only)
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when the response has fully unloaded
- si  input  1  serial scan-in data
- si_valid  input  1  si holds a valid bit
- si_ready  output  1  port accepts si this cycle
- so  output  1  serial scan-out data
- so_valid  output  1  so holds a valid response bit
- so_ready  input  1  tester accepts so this cycle
- core_in  output  IN_W  applied vector to the core
- core_out  input  OUT_W  core response
- vec_count  output  16  number of completed sequences since reset

Behaviour:
- Reset (sync, high): state=IDLE; all outputs 0, including core_in, vec_count, done, si_ready and so_valid; shift and response registers 0. Reset mid-sequence aborts immediately; no done pulse.
- States: IDLE, LOAD, APPLY, CAPTURE, UNLOAD, DONE.
- IDLE:
  - si_ready=0, so_valid=0.
  - start=1 -> LOAD; bit counter cleared.
  - start while busy is ignored.
- LOAD:
  - si_ready=1.
  - Each cycle with si_valid&si_ready: shift_reg <= {shift_reg[IN_W-2:0], si}, so the first bit received ends as MSB.
  - Gaps in si_valid stall without loss.
  - After the IN_W-th accepted bit -> APPLY. si_ready drops the cycle after.
- core_in:
  - Updated from shift_reg only on the LOAD->APPLY transition.
  - Holds the previous vector throughout LOAD, so the core never sees partially shifted patterns.
- APPLY:
  - Counts SETTLE cycles.
  - With SETTLE=1, exactly one cycle in APPLY with the new core_in stable, then -> CAPTURE.
- CAPTURE:
  - One cycle; resp_reg <= core_out.
  - -> UNLOAD.
- UNLOAD:
  - so_valid=1; so=resp_reg[OUT_W-1], MSB first.
  - On so_valid&so_ready: resp_reg shifts left and the counter increments.
  - so_ready low holds so/so_valid stable.
  - After the OUT_W-th transfer -> DONE.
- DONE:
  - done=1 for exactly one cycle.
  - vec_count increments, saturating at 16'hFFFF.
  - -> IDLE.
  - start asserted in DONE is ignored; it must be re-sampled in IDLE.
- Latency, start to done with no stalls: 1 + IN_W + SETTLE + 1 + OUT_W + 1 cycles (=9 for the defaults).
- core_in retains the last applied vector in IDLE until the next APPLY.

Decomposition:
- Shared package scan_pkg:
  - state enum scan_state_t (IDLE, LOAD, APPLY, CAPTURE, UNLOAD, DONE);
  - default widths SCAN_IN_W=4, SCAN_OUT_W=1;
  - VEC_CNT_W=16.
- One natural sub-module, scan_shift_reg:
  - parameterised width;
  - shift-enable, serial in/out, parallel load/out.
  - Instantiated twice: the scan-in chain and the response chain.
- FSM and counters stay in the top module.

Test Plan (bench core model: core_out = ^core_in, OUT_W=1):
- Reset then idle: after reset, core_in=0, vec_count=0, busy=0, si_ready=0, so_valid=0 -> all hold for 10 idle cycles.
- Basic vector: start, shift bits 0,0,1,1 with continuous si_valid.
  - core_in=4'b0011 exactly 1 cycle after the 4th accept;
  - so=0 with so_valid;
  - done pulses at cycle 9 after start;
  - vec_count=1.
- Stalls:
  - Vector 0111 with si_valid gaps of 3 cycles between bits, and so_ready held low 5 cycles.
  - Required: core_in=4'b0111 (unchanged during the gaps); so=1 held stable throughout the stall; done once; vec_count increments by 1.
- No glitch during load: after vector 1100, load 0001. core_in stays 4'b1100 for every LOAD cycle, then becomes 4'b0001.
- Start while busy: assert start during LOAD and UNLOAD -> no restart and no extra done. Run all seven vectors 0000..1100 back-to-back -> vec_count=7.
- Reset mid-sequence: assert reset after 2 bits loaded -> next cycle state=IDLE, outputs 0, no done pulse. A following full sequence completes normally with vec_count=1.
